// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-handshake types and constants for pipe_mux_n and pipe_skid_reg.
package pipe_pkg;
    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 16;
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
endpackage

// File: rtl/pipe_mux_n_if.sv
// pipe_mux_n_if: input beat, select, flush and output handshake bundle of pipe_mux_n.
interface pipe_mux_n_if #(
    parameter int DATA_SIZE = 32,
    parameter int NUM_IN    = 4
);
    localparam int SEL_W = $clog2(NUM_IN);
    logic [NUM_IN*DATA_SIZE-1:0] in_data;
    logic [SEL_W-1:0]            sel;
    logic                        in_valid;
    logic                        in_ready;
    logic                        flush;
    logic [DATA_SIZE-1:0]        out_data;
    logic                        out_sel_err;
    logic                        out_valid;
    logic                        out_ready;
    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid
    );
    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel_err, out_valid
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: 2-entry (main + skid) handshake register for an {err, data} beat.
// in_ready is registered, so there is no combinational out_ready -> in_ready path.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_err,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_err,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);
    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } beat_t;
    state_t state;
    beat_t  main_q;
    beat_t  skid_q;
    beat_t  in_beat;
    logic   acc;
    assign in_beat = '{err: in_err, data: in_data};
    assign acc     = in_valid && in_ready;
    assign out_err  = main_q.err;
    assign out_data = main_q.data;
    // flush outranks both accept and completion, so it is checked before the state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    main_q    <= in_beat;
                    out_valid <= 1'b1;
                    state     <= BUSY;
                end
                BUSY: if (acc && !out_ready) begin
                    skid_q   <= in_beat;
                    in_ready <= 1'b0;
                    state    <= FULL;
                end else if (acc) begin
                    main_q <= in_beat;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
                FULL: if (out_ready) begin
                    main_q   <= skid_q;
                    in_ready <= 1'b1;
                    state    <= BUSY;
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end
endmodule

// File: rtl/pipe_mux_n.sv
// pipe_mux_n: registered N-way operand select with valid/ready, flush and out-of-range select flag.
// Define PIPE_MUX_SKID_EN for the 2-entry skid buffer; otherwise a single output register is used.
module pipe_mux_n
    import pipe_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int NUM_IN    = 4
) (
    input logic         clk,
    input logic         rst_n,
    pipe_mux_n_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_IN);
    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
        $error("pipe_mux_n: NUM_IN out of range");
    end
    logic [DATA_SIZE-1:0] sel_data;
    logic                 sel_err;
    // an out-of-range select matches no input, leaving the data at zero
    always_comb begin
        sel_err  = int'(bus.sel) >= NUM_IN;
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++)
            sel_data = (bus.sel == SEL_W'(k)) ? bus.in_data[k*DATA_SIZE +: DATA_SIZE] : sel_data;
    end
`ifdef PIPE_MUX_SKID_EN
    pipe_skid_reg #(.DW(DATA_SIZE)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.flush),
        .in_err   (sel_err),
        .in_data  (sel_data),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .out_err  (bus.out_sel_err),
        .out_data (bus.out_data),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready)
    );
`else
    logic                 valid_q;
    logic                 err_q;
    logic [DATA_SIZE-1:0] data_q;
    assign bus.in_ready    = !valid_q || bus.out_ready;
    assign bus.out_valid   = valid_q;
    assign bus.out_sel_err = err_q;
    assign bus.out_data    = data_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (bus.in_valid && bus.in_ready) begin
            valid_q <= 1'b1;
            err_q   <= sel_err;
            data_q  <= sel_data;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
`endif
endmodule
